// File: rtl/hex_readout_ctrl.sv
// hex_readout_ctrl: draws a NUM_DIGITS-wide hex readout at (X0,Y0), magnified
// by 2^SCALE_LOG2. During horizontal blank it fetches the glyph row for the
// next scanline from the 8x8 hex glyph ROM into a line buffer. During the
// active region it produces a registered pixel_on for the colour mux.
module hex_readout_ctrl #(
    parameter int         NUM_DIGITS = 4,
    parameter logic [9:0] X0         = 10'd16,
    parameter logic [9:0] Y0         = 10'd16,
    parameter int         SCALE_LOG2 = 1,
    parameter logic [9:0] FETCH_X    = 10'd640,
    parameter logic [9:0] V_TOTAL    = 10'd525
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [9:0]              hcount,
    input  logic [9:0]              vcount,
    input  logic                    frame_start,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic                    value_load,
    output logic                    glyph_en,
    output logic [7:0]              glyph_value,
    input  logic [63:0]             glyph,
    output logic                    pixel_on,
    output logic                    busy
);

    localparam int         VW     = 4 * NUM_DIGITS;
    localparam logic [2:0] LAST_K = 3'(NUM_DIGITS - 1);
    localparam logic [9:0] SPAN   = 10'(8 * NUM_DIGITS);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [2:0]      k;
    logic [2:0]      row_q;
    logic [VW-1:0]   pending;
    logic [VW-1:0]   display;
    logic            copy_deferred;
    logic [7:0]      addr_q;
    logic [7:0]      linebuf [8];

    logic [9:0]      next_line;
    logic [9:0]      rel_line;
    logic [9:0]      row_full;
    logic            row_valid;
    logic            fetch_hit;
    logic            start_fetch;
    logic            clear_buf;
    logic [3:0]      digits [8];
    logic [7:0]      issue_addr;
    logic [7:0]      glyph_byte;
    logic            capture;
    logic [2:0]      cap_slot;
    logic [9:0]      x_off;
    logic [9:0]      relx;
    logic            in_span;
    logic            pix_bit;

    // Target scanline for the next fetch and which glyph row it needs.
    always_comb begin
        next_line = (vcount == V_TOTAL - 10'd1) ? 10'd0 : vcount + 10'd1;
        rel_line  = next_line - Y0;
        row_full  = rel_line >> SCALE_LOG2;
        row_valid = (next_line >= Y0) && (row_full < 10'd8);
        fetch_hit = (hcount == FETCH_X);
    end

    // Split the displayed value into digits, leftmost first; unused slots read 0.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            digits[i] = 4'h0;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digits[i] = display[VW-1-4*i -: 4];
        end
        issue_addr = {4'h0, digits[k]};
    end

    // Next-state and ROM request decode for the fetch sequencer.
    // NOTE: every output of this block is given a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_next  = state;
        glyph_en    = 1'b0;
        start_fetch = 1'b0;
        clear_buf   = 1'b0;
        unique case (state)
            IDLE: begin
                if (fetch_hit) begin
                    if (row_valid) begin
                        start_fetch = 1'b1;
                        state_next  = ISSUE;
                    end else begin
                        clear_buf = 1'b1;
                    end
                end
            end
            ISSUE: begin
                glyph_en = 1'b1;
                if (k == LAST_K) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The address is live while issuing and otherwise holds the last one sent.
    assign glyph_value = (state == ISSUE) ? issue_addr : addr_q;
    assign busy        = (state != IDLE);

    // State register, digit counter and latched glyph row for this fetch.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement or block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            k     <= 3'd0;
            row_q <= 3'd0;
        end else begin
            state <= state_next;
            if (start_fetch) begin
                k     <= 3'd0;
                row_q <= row_full[2:0];
            end else if (state == ISSUE) begin
                k <= k + 3'd1;
            end
        end
    end

    // Hold the most recent ROM address once the burst is over.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= 8'h00;
        end else if (state == ISSUE) begin
            addr_q <= issue_addr;
        end
    end

    // Pending/display value registers; a frame_start seen mid-fetch is
    // remembered and applied on the first idle cycle so a line never mixes
    // digits from two values.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending       <= '0;
            display       <= '0;
            copy_deferred <= 1'b0;
        end else begin
            if (value_load) begin
                pending <= value_in;
            end
            if ((state == IDLE) && (frame_start || copy_deferred)) begin
                display       <= value_load ? value_in : pending;
                copy_deferred <= 1'b0;
            end else if (frame_start) begin
                copy_deferred <= 1'b1;
            end
        end
    end

    // Returning ROM data lags the request by one cycle, so slot k-1 is
    // written while digit k is requested and the last slot lands in DRAIN.
    always_comb begin
        glyph_byte = glyph[{3'd7 - row_q, 3'b000} +: 8];
        capture    = ((state == ISSUE) && (k != 3'd0)) || (state == DRAIN);
        cap_slot   = (state == DRAIN) ? LAST_K : k - 3'd1;
    end

    // Line buffer: filled by a fetch, cleared for lines outside the readout.
    // NOTE: this small buffer is reset on purpose; a reset mid-fetch must not
    // leave a partially captured row visible on the next line.
    always_ff @(posedge clk) begin
        if (reset || clear_buf) begin
            for (int i = 0; i < 8; i++) begin
                linebuf[i] <= 8'h00;
            end
        end else if (capture) begin
            linebuf[cap_slot] <= glyph_byte;
        end
    end

    // Map the current column onto a line buffer bit.
    always_comb begin
        x_off   = hcount - X0;
        relx    = x_off >> SCALE_LOG2;
        in_span = (hcount >= X0) && (relx < SPAN);
        pix_bit = linebuf[relx[5:3]][relx[2:0]];
    end

    // Registered pixel output, one cycle behind hcount.
    always_ff @(posedge clk) begin
        if (reset) begin
            pixel_on <= 1'b0;
        end else begin
            pixel_on <= in_span && pix_bit;
        end
    end

endmodule

// File: tb/tb_hex_readout_ctrl.sv
// Scoreboard bench for hex_readout_ctrl: stimulus pushes expectations into
// queues, a negedge monitor pops and compares when the DUT presents data.
module tb_hex_readout_ctrl;

    logic        clk;
    logic        reset;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic        frame_start;
    logic [15:0] value_in;
    logic        value_load;
    logic        glyph_en,   glyph_en_b;
    logic [7:0]  glyph_value, glyph_value_b;
    logic [63:0] glyph,      glyph_b;
    logic        pixel_on,   pixel_on_b;
    logic        busy,       busy_b;

    // Main instance uses defaults; the second has Y0=0 for the frame-wrap case.
    hex_readout_ctrl u_dut (
        .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
        .frame_start(frame_start), .value_in(value_in), .value_load(value_load),
        .glyph_en(glyph_en), .glyph_value(glyph_value), .glyph(glyph),
        .pixel_on(pixel_on), .busy(busy)
    );

    hex_readout_ctrl #(.Y0(10'd0)) u_dut_wrap (
        .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
        .frame_start(frame_start), .value_in(value_in), .value_load(value_load),
        .glyph_en(glyph_en_b), .glyph_value(glyph_value_b), .glyph(glyph_b),
        .pixel_on(pixel_on_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench font: row 0 blank, row 1 of '8' and 'A' as drawn, other rows coded.
    function automatic logic [7:0] rom_row(input logic [3:0] d, input int r);
        logic [2:0] rr;
        rr = r[2:0];
        if (r == 0) return 8'h00;
        if (d == 4'h8 && r == 1) return 8'h1C;
        if (d == 4'hA && r == 1) return 8'h18;
        return {rr, 1'b1, d};
    endfunction

    function automatic logic [63:0] font_glyph(input logic [3:0] d);
        logic [63:0] g;
        g = '0;
        for (int r = 0; r < 8; r++) g[63-8*r -: 8] = rom_row(d, r);
        return g;
    endfunction

    // Expected pixel for column h; row < 0 means the line buffer is clear.
    function automatic int exp_pixel(input logic [15:0] dv, input int row, input int h);
        int         relx;
        logic [3:0] d;
        logic [7:0] b;
        if (row < 0 || row > 7 || h < 16) return 0;
        relx = (h - 16) >> 1;
        if (relx >= 32) return 0;
        d = dv[15-4*(relx/8) -: 4];
        b = rom_row(d, row);
        return int'(b[relx%8]);
    endfunction

    // Glyph ROM models: data one cycle after the enable.
    always @(posedge clk) begin
        if (glyph_en)   glyph   <= font_glyph(glyph_value[3:0]);
        if (glyph_en_b) glyph_b <= font_glyph(glyph_value_b[3:0]);
    end

    // Scoreboard queues and bench-side valid strobes.
    logic [7:0]  exp_addr[$];
    logic [7:0]  exp_addr_b[$];
    int          exp_busy[$];
    int          exp_busy_b[$];
    int          exp_pix[$];
    logic [11:0] exp_stat[$];
    string       stat_name[$];
    logic        chk_pix, chk_stat, pix_v, stat_v, done;

    always @(posedge clk) begin
        pix_v  <= chk_pix;
        stat_v <= chk_stat;
    end

    int n_vec = 0;
    int n_bad = 0;
    int busy_run = 0;
    int busy_run_b = 0;
    int cyc = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: compare whatever the DUTs present on this cycle.
    always @(negedge clk) begin
        int          v;
        logic [11:0] act;
        cyc++;
        if (glyph_en) begin
            if (exp_addr.size() == 0) check("glyph_en_unexpected", 1, 0);
            else check("glyph_value", 32'(glyph_value), 32'(exp_addr.pop_front()));
        end
        if (glyph_en_b) begin
            if (exp_addr_b.size() == 0) check("wrap_glyph_en_unexpected", 1, 0);
            else check("wrap_glyph_value", 32'(glyph_value_b), 32'(exp_addr_b.pop_front()));
        end
        if (busy) busy_run++;
        else if (busy_run != 0) begin
            if (exp_busy.size() == 0) check("busy_unexpected", 32'(busy_run), 0);
            else check("busy_len", 32'(busy_run), 32'(exp_busy.pop_front()));
            busy_run = 0;
        end
        if (busy_b) busy_run_b++;
        else if (busy_run_b != 0) begin
            if (exp_busy_b.size() == 0) check("wrap_busy_unexpected", 32'(busy_run_b), 0);
            else check("wrap_busy_len", 32'(busy_run_b), 32'(exp_busy_b.pop_front()));
            busy_run_b = 0;
        end
        if (pix_v) begin
            if (exp_pix.size() == 0) check("pixel_queue_underflow", 1, 0);
            else begin
                v = exp_pix.pop_front();
                check($sformatf("pixel_on@h%0d", v >> 1), 32'(pixel_on), 32'(v & 1));
            end
        end
        if (stat_v) begin
            act = {glyph_en, busy, pixel_on, pixel_on_b, glyph_value};
            if (exp_stat.size() == 0) check("status_queue_underflow", 1, 0);
            else check(stat_name.pop_front(), 32'(act), 32'(exp_stat.pop_front()));
        end
        if (done || cyc > 20000) begin
            if (!done) check("timeout", 1, 0);
            check("addr_left",   32'(exp_addr.size()),   0);
            check("addr_b_left", 32'(exp_addr_b.size()), 0);
            check("busy_left",   32'(exp_busy.size()),   0);
            check("busy_b_left", 32'(exp_busy_b.size()), 0);
            check("pix_left",    32'(exp_pix.size()),    0);
            check("stat_left",   32'(exp_stat.size()),   0);
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
            $finish;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expect {glyph_en, busy, pixel_on, pixel_on_b, glyph_value} after the next edge.
    task automatic push_stat(input string nm, input logic [11:0] v);
        stat_name.push_back(nm);
        exp_stat.push_back(v);
        chk_stat = 1'b1;
        tick();
        chk_stat = 1'b0;
    endtask

    // Present hcount==FETCH_X on line v and let any fetch run to completion.
    task automatic kick(input logic [9:0] v);
        vcount = v;
        hcount = 10'd640;
        tick();
        hcount = 10'd641;
        repeat (6) tick();
        hcount = 10'd600;
    endtask

    // Fetch expected on the main DUT: four addresses, 5-cycle busy, then hold.
    task automatic fetch(input logic [9:0] v, input logic [15:0] dv);
        for (int i = 0; i < 4; i++) exp_addr.push_back({4'h0, dv[15-4*i -: 4]});
        exp_busy.push_back(5);
        kick(v);
        push_stat("addr_hold", {4'b0000, 4'h0, dv[3:0]});
    endtask

    task automatic sweep(input logic [9:0] v, input logic [15:0] dv, input int row);
        vcount = v;
        for (int h = 0; h < 96; h++) begin
            hcount  = 10'(h);
            chk_pix = 1'b1;
            exp_pix.push_back(h * 2 + exp_pixel(dv, row, h));
            tick();
        end
        chk_pix = 1'b0;
        hcount  = 10'd600;
        tick();
    endtask

    task automatic load_and_frame(input logic [15:0] v, input bit same_cycle);
        value_in   = v;
        value_load = 1'b1;
        if (same_cycle) frame_start = 1'b1;
        tick();
        value_load  = 1'b0;
        frame_start = 1'b1;
        if (same_cycle) frame_start = 1'b0;
        else tick();
        frame_start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; hcount = 10'd600; vcount = 10'd0; frame_start = 1'b0;
        value_in = 16'h0; value_load = 1'b0; chk_pix = 1'b0; chk_stat = 1'b0;
        done = 1'b0; glyph = '0; glyph_b = '0;
        repeat (2) tick();
        push_stat("reset_state", 12'h000);
        reset = 1'b0;

        // Basic fetch: row 0 is blank, row 1 shows 'A' in slot 1.
        load_and_frame(16'h1A3F, 1'b0);
        fetch(10'd15, 16'h1A3F);
        sweep(10'd16, 16'h1A3F, 0);
        fetch(10'd17, 16'h1A3F);
        sweep(10'd18, 16'h1A3F, 1);

        // Row 8 is past the glyph: no fetch, buffer cleared.
        kick(10'd31);
        sweep(10'd32, 16'h0, -1);

        // Digit 8 row 1: lit at X0+4..X0+9.
        load_and_frame(16'h8000, 1'b0);
        fetch(10'd17, 16'h8000);
        sweep(10'd18, 16'h8000, 1);

        // Frame wrap: last line targets row 0 on the Y0=0 instance only.
        for (int i = 0; i < 4; i++) exp_addr_b.push_back({4'h0, 4'((i == 0) ? 8 : 0)});
        exp_busy_b.push_back(5);
        kick(10'd524);
        kick(10'd523);

        // New value with frame_start during DRAIN: fetch keeps old digits.
        for (int i = 0; i < 4; i++) exp_addr.push_back({4'h0, 4'((i == 0) ? 8 : 0)});
        exp_busy.push_back(5);
        vcount = 10'd17;
        hcount = 10'd640;
        tick();
        hcount = 10'd641;
        repeat (4) tick();
        value_in = 16'hBEEF; value_load = 1'b1; frame_start = 1'b1;
        push_stat("drain_exit", 12'h000);
        value_load = 1'b0; frame_start = 1'b0;
        repeat (2) tick();
        fetch(10'd17, 16'hBEEF);
        sweep(10'd18, 16'hBEEF, 1);

        // Reset at k=2: three addresses issued, everything back to reset values.
        exp_addr.push_back(8'h0B);
        exp_addr.push_back(8'h0E);
        exp_addr.push_back(8'h0E);
        exp_busy.push_back(3);
        vcount = 10'd17;
        hcount = 10'd640;
        tick();
        hcount = 10'd641;
        repeat (2) tick();
        reset = 1'b1;
        push_stat("reset_mid_fetch", 12'h000);
        reset = 1'b0;
        sweep(10'd18, 16'h0, -1);
        fetch(10'd17, 16'h0000);

        // Load and frame_start together take value_in directly.
        load_and_frame(16'h1A3F, 1'b1);
        fetch(10'd17, 16'h1A3F);
        sweep(10'd18, 16'h1A3F, 1);

        repeat (3) tick();
        done = 1'b1;
    end

endmodule

// File: doc/hex_readout_ctrl.md
Name: hex_readout_ctrl

Overview:
- Sequences the 8x8 hex glyph ROM to draw a NUM_DIGITS-wide hex readout (score/ID) at screen position (X0,Y0), magnified by 2^SCALE_LOG2.
- Once per scanline, during horizontal blank, it fetches the glyph row needed for the next line into a line buffer.
- During the active region it emits a registered pixel_on to the VGA colour mux.
- Sits between the VGA timing generator and the glyph ROM; it is the ROM's only requester.

Parameters:
- NUM_DIGITS, 4, hex digits displayed, MSB digit leftmost (1..8).
- X0, 10'd16, left pixel column of the readout.
- Y0, 10'd16, top scanline of the readout.
- SCALE_LOG2, 1, glyph magnification as a power of two (0..3).
- FETCH_X, 10'd640, hcount value that triggers the next-line fetch.
- V_TOTAL, 10'd525, total lines per frame.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- hcount  in  10  current pixel column from the VGA timing block
- vcount  in  10  current scanline from the VGA timing block
- frame_start  in  1  one-cycle pulse at the start of each frame
- value_in  in  4*NUM_DIGITS  value to display
- value_load  in  1  latch value_in into the pending register
- glyph_en  out  1  glyph ROM read enable
- glyph_value  out  8  glyph ROM address (digit, zero-extended)
- glyph  in  64  glyph ROM data, valid one cycle after glyph_en
- pixel_on  out  1  readout pixel lit
- busy  out  1  fetch in progress

Behaviour:
- Reset values: glyph_en=0, glyph_value=0, pixel_on=0, busy=0, pending=0, display=0, line buffer=0, state=IDLE.
- Glyph layout: row r (0=top) occupies glyph[63-8r:56-8r]. Column c (0=left) is bit (56-8r+c).
- Value registers:
  - value_load latches value_in into pending.
  - On frame_start in IDLE, display <= pending.
  - If frame_start arrives while busy, the copy is deferred to the first IDLE cycle after the fetch ends.
  - value_load and frame_start in the same cycle: display <= value_in; pending <= value_in.
- Target line: nl = (vcount==V_TOTAL-1) ? 0 : vcount+1. rel = nl - Y0 (unsigned, 10 bits). row = rel >> SCALE_LOG2. The row is valid iff nl >= Y0 and row < 8.
- States: IDLE, ISSUE, DRAIN.
- IDLE:
  - On hcount==FETCH_X with a valid row: set k=0, go to ISSUE, busy=1.
  - On hcount==FETCH_X with an invalid row: clear the line buffer in that cycle and stay in IDLE.
- ISSUE:
  - Each cycle: glyph_en=1, glyph_value={4'b0, display digit k}. Digit 0 is display[4*NUM_DIGITS-1 -: 4].
  - When k>0, capture the returning glyph row into line buffer slot k-1.
  - k increments each cycle. After issuing k=NUM_DIGITS-1, go to DRAIN.
- DRAIN: glyph_en=0. Capture slot NUM_DIGITS-1. Go to IDLE, busy=0.
- Fetch duration: NUM_DIGITS+1 cycles. glyph_value holds its last address while glyph_en=0.
- Pixel output, registered with 1-cycle latency:
  - relx = (hcount - X0) >> SCALE_LOG2.
  - pixel_on <= (hcount >= X0) && (relx < 8*NUM_DIGITS) && linebuf[relx>>3][relx[2:0]].
- The line buffer is written only during fetch/clear. The fetch always runs at FETCH_X, after the active region, so there is no tearing within a line.
- Reset mid-fetch: return to IDLE on the next edge. Outputs return to reset values and the line buffer is cleared; no partial capture survives.
- hcount==FETCH_X while busy (cannot occur in valid timing): ignored.

Test Plan:
- Reset, value_load 16'h1A3F, frame_start, then line with nl=Y0 at FETCH_X -> glyph_value sequence 8'h01,8'h0A,8'h03,8'h0F over 4 cycles with glyph_en=1; busy high 5 cycles; line buffer slot 1 = 8'b00011000 (top row of 'A' after the blank row 0? row 0 -> 8'h00 for all digits).
- Same setup, nl=Y0+2*8 (SCALE_LOG2=1, row 8) -> no glyph_en pulses; line buffer cleared; pixel_on 0 across the whole line.
- Display digit 8, row 1 (byte 8'b00011100) -> pixel_on=1 at hcount X0+4..X0+9 (cols 2,3,4 doubled), 1 cycle after hcount; 0 at X0+3 and X0+10.
- vcount=V_TOTAL-1 with Y0=0 -> fetch targets row 0 (nl wraps to 0).
- value_load 16'hBEEF while busy together with frame_start -> current fetch keeps old digits; display becomes 16'hBEEF the cycle after DRAIN; the next fetch issues 0B,0E,0E,0F.
- reset asserted during ISSUE at k=2 -> next cycle glyph_en=0, busy=0, pixel_on=0, line buffer all zero; normal fetch resumes at next FETCH_X.
